arm_fetch_unit: RTL and testbench
=================================

Name: arm_fetch_unit

Overview:
Instruction-fetch front end feeding the decode stage of the ARM core under `top`. It owns the PC and issues word reads to instruction memory with at most one read outstanding. Returned words are buffered in a small prefetch FIFO and presented to decode over a valid/ready handshake. It also redirects fetch and flushes the FIFO on taken branches.

Parameters:
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.
- DEPTH, 2, prefetch FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, PC loaded at reset; word aligned.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request, one-cycle pulse.
- imem_addr  out  ADDR_W  word address of the request.
- imem_rvalid  in  1  read data valid; arrives ≥1 cycle after imem_req.
- imem_rdata  in  DATA_W  instruction word.
- br_taken  in  1  redirect pulse from execute.
- br_target  in  ADDR_W  redirect address.
- if_valid  out  1  FIFO head valid to decode.
- if_ready  in  1  decode accepts the head.
- if_instr  out  DATA_W  head instruction.
- if_pc  out  ADDR_W  address of the head instruction.

Behaviour:
- Reset values: state=RUN, pc=RESET_PC, count=0, rd/wr ptr=0. Outputs imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
- if_valid = (count!=0); if_instr/if_pc come from registered FIFO storage; no combinational path from imem_rdata.
- FSM states:
  - RUN: assert imem_req when (count + pop_this_cycle_adjusted) < DEPTH, i.e. a free slot is guaranteed for the response. imem_addr=pc. On issue: pc <= pc+4 (wraps mod 2^ADDR_W), go WAIT.
  - WAIT: on imem_rvalid, push {issued_pc, imem_rdata}, go RUN. No new request in the same cycle; issue resumes next cycle.
  - DROP: the outstanding response is stale. On imem_rvalid, discard the data and go RUN.
- Pop: if_valid && if_ready; the head advances the next cycle.
- Push and pop in the same cycle: count unchanged.
- Full FIFO (count==DEPTH): no request issued; a response never overflows, by the issue rule.
- br_taken (highest priority):
  - Same cycle: count<=0, ptrs<=0, pc<=br_target with bits[1:0] forced 0.
  - In RUN: no request that cycle; request to the target next cycle.
  - In WAIT without imem_rvalid: go DROP.
  - In WAIT with imem_rvalid: discard the data, go RUN.
  - In DROP: stay in DROP, retarget pc.
  - A pop coinciding with br_taken is still consumed by decode; the FIFO is then cleared.
- Latency with 1-cycle memory: req at cycle 0, push at cycle 1, if_valid high at cycle 2. Sustained throughput is 1 instruction per 2 cycles, by the single-outstanding design.
- rst mid-transaction: all state cleared immediately. A later stray imem_rvalid in RUN is ignored.

Optional Feature:
- FETCH_STATS_EN defined: adds output stat_flush_cnt [15:0]. It increments on every br_taken, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package arm_core_pkg:
  - fetch state enum (RUN, WAIT, DROP)
  - PC_STEP=4
  - struct fetch_entry_t {pc, instr}
- One natural sub-module: arm_prefetch_fifo. It is a synchronous FIFO with push, pop and flush, and count, full and empty outputs. Flush takes priority over push.

Test Plan:
- Reset release, 1-cycle memory returning addr-based data, if_ready=1 → requests to 0x0, 0x4, 0x8. if_pc 0x0 with if_instr=mem[0] first valid 2 cycles after rst falls.
- if_ready=0 for 10 cycles → count reaches 2, imem_req stays 0. Raise if_ready → entries pop in order 0x0, 0x4, then fetch resumes at 0x8.
- br_taken, br_target=0x103 in RUN with count=2 → if_valid=0 next cycle, next imem_addr=0x100. No stale entry is delivered.
- 3-cycle memory latency, br_taken in WAIT → FSM goes DROP, the stale response is discarded, and the next request is to the target. The first if_pc equals the target.
- br_taken in the same cycle as imem_rvalid → the data is not pushed and the FSM goes directly to RUN. Also assert rst mid-WAIT → all outputs return to reset values in the same cycle.
- FETCH_STATS_EN build: 3 branches → stat_flush_cnt=3. Preload at 16'hFFFF, then one more branch → stays 16'hFFFF.

Source files
------------

// File: rtl/arm_core_pkg.sv
// Shared types for the ARM core front end: fetch FSM states, PC increment and
// the default prefetch entry layout.
package arm_core_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam int PC_STEP      = 4;
    localparam int ENTRY_ADDR_W = 32;
    localparam int ENTRY_DATA_W = 32;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] pc;
        logic [ENTRY_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/arm_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, branch redirect, decode
// handshake and FSM/FIFO observability.
interface arm_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
);
    import arm_core_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    fetch_state_t      fsm_state;
    logic [CNT_W-1:0]  fifo_count;

    // Decode handshake: a transfer happens on every rising edge where
    // if_valid && if_ready; if_valid never depends on if_ready.
    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, fsm_state, fifo_count,
        input  imem_rvalid, imem_rdata, br_taken, br_target, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, fsm_state, fifo_count,
        output imem_rvalid, imem_rdata, br_taken, br_target, if_ready
    );

endinterface

// File: rtl/arm_prefetch_fifo.sv
// Small synchronous prefetch FIFO with push, pop and flush; flush wins over
// push and pop.
module arm_prefetch_fifo
    import arm_core_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  entry_t               din,
    output entry_t               dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                 full,
    output logic                 empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    assign do_pop = pop && !empty;
    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/arm_fetch_unit.sv
// Instruction fetch front end: single-outstanding imem reads into a prefetch
// FIFO, with branch redirect. Define FETCH_STATS_EN to add stat_flush_cnt.
module arm_fetch_unit
    import arm_core_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    arm_fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]      stat_flush_cnt
`endif
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] issued_pc;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    logic              issue;
    entry_t            head;
    entry_t            wr_entry;

    // A request goes out only if its response is sure to find a free slot,
    // counting a slot freed by this cycle's pop.
    assign pop      = !empty && bus.if_ready;
    assign issue    = !rst && (state == RUN) && !bus.br_taken && (!full || pop);
    assign push     = (state == WAIT) && bus.imem_rvalid && !bus.br_taken;
    assign wr_entry = '{pc: issued_pc, instr: bus.imem_rdata};

    arm_prefetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.br_taken),
        .din   (wr_entry),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign bus.imem_req   = issue;
    assign bus.imem_addr  = pc;
    assign bus.if_valid   = !empty;
    assign bus.if_instr   = empty ? '0 : head.instr;
    assign bus.if_pc      = empty ? '0 : head.pc;
    assign bus.fsm_state  = state;
    assign bus.fifo_count = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            pc        <= RESET_PC;
            issued_pc <= RESET_PC;
        end else if (bus.br_taken) begin
            pc <= bus.br_target & ~ADDR_W'(3);
            // An outstanding read becomes stale; if it lands now it is simply dropped.
            case (state)
                RUN:     state <= RUN;
                default: state <= bus.imem_rvalid ? RUN : DROP;
            endcase
        end else begin
            case (state)
                RUN: begin
                    if (issue) begin
                        issued_pc <= pc;
                        pc        <= pc + ADDR_W'(PC_STEP);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        state <= RUN;
                    end
                end
                DROP: begin
                    if (bus.imem_rvalid) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_flush_cnt <= '0;
        end else if (bus.br_taken && (stat_flush_cnt != 16'hFFFF)) begin
            stat_flush_cnt <= stat_flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Directed bench for arm_fetch_unit with a variable-latency instruction memory.
`timescale 1ns/1ps
module tb_arm_fetch_unit;
  import arm_core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int lat = 1;

  logic [31:0] got_pc_q[$];
  logic [31:0] got_in_q[$];
  logic [31:0] req_q[$];
  logic [31:0] exp_q[$];

  bit mem_busy = 1'b0;
  int mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  arm_fetch_unit_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) bus();

`ifdef FETCH_STATS_EN
  logic [15:0] stat_flush_cnt;
`endif

  arm_fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(2), .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_STATS_EN
    , .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hE59F_0000;
  endfunction

  // instruction memory: response 'lat' cycles after the request cycle
  always @(posedge clk) begin
    bus.imem_rvalid <= 1'b0;
    if (mem_busy) begin
      if (mem_cnt == 1) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= mem_word(mem_addr);
        mem_busy <= 1'b0;
      end else begin
        mem_cnt <= mem_cnt - 1;
      end
    end
    if (bus.imem_req) begin
      if (lat == 1) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= mem_word(bus.imem_addr);
      end else begin
        mem_busy <= 1'b1;
        mem_cnt  <= lat - 1;
        mem_addr <= bus.imem_addr;
      end
    end
  end

  // monitor: delivered entries and issued requests
  always @(negedge clk) begin
    if (bus.if_valid && bus.if_ready) begin
      got_pc_q.push_back(bus.if_pc);
      got_in_q.push_back(bus.if_instr);
    end
    if (bus.imem_req) req_q.push_back(bus.imem_addr);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_pc_q.delete();
    got_in_q.delete();
    req_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset(input int l, input logic rdy);
    rst = 1'b1;
    lat = l;
    bus.if_ready = rdy;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    repeat (5) tick();
    clear_q();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lat = 1;
    bus.if_ready = 1'b1;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    repeat (3) tick();
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", bus.imem_req); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", bus.imem_addr); end
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", bus.if_valid); end
    total++; if (bus.if_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%0h exp=0", bus.if_instr); end
    total++; if (bus.if_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%0h exp=0", bus.if_pc); end
    clear_q();
    rst = 1'b0;
    #1;
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%0h exp=1", bus.imem_req); end
    tick();
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL early_valid got=%0h exp=0", bus.if_valid); end
    tick();
    total++; if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%0h exp=1", bus.if_valid); end
    total++; if (bus.if_pc !== 32'h0) begin bad++; $display("FAIL lat_pc got=%0h exp=0", bus.if_pc); end
    total++; if (bus.if_instr !== mem_word(32'h0)) begin bad++; $display("FAIL lat_instr got=%0h exp=%0h", bus.if_instr, mem_word(32'h0)); end
    for (int i = 0; i < 20 && got_pc_q.size() < 3; i++) tick();
    total++; if (got_pc_q.size() < 3) begin bad++; $display("FAIL reset_stream_timeout got=%0d exp=3", got_pc_q.size()); end
    exp_q = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) begin
      total++; if (i >= got_pc_q.size() || got_pc_q[i] !== exp_q[i] || got_in_q[i] !== mem_word(exp_q[i]))
        begin bad++; $display("FAIL reset_stream[%0d] got=%0h exp=%0h", i, got_pc_q[i], exp_q[i]); end
      total++; if (i >= req_q.size() || req_q[i] !== exp_q[i])
        begin bad++; $display("FAIL reset_req[%0d] got=%0h exp=%0h", i, req_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    do_reset(1, 1'b0);
    repeat (10) tick();
    total++; if (bus.fifo_count !== 2'd2) begin bad++; $display("FAIL stall_count got=%0d exp=2", bus.fifo_count); end
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%0h exp=0", bus.imem_req); end
    total++; if (req_q.size() != 2) begin bad++; $display("FAIL stall_nreq got=%0d exp=2", req_q.size()); end
    total++; if (bus.if_pc !== 32'h0) begin bad++; $display("FAIL stall_head got=%0h exp=0", bus.if_pc); end
    clear_q();
    bus.if_ready = 1'b1;
    for (int i = 0; i < 20 && got_pc_q.size() < 3; i++) tick();
    total++; if (got_pc_q.size() < 3) begin bad++; $display("FAIL stall_timeout got=%0d exp=3", got_pc_q.size()); end
    exp_q = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) begin
      total++; if (i >= got_pc_q.size() || got_pc_q[i] !== exp_q[i] || got_in_q[i] !== mem_word(exp_q[i]))
        begin bad++; $display("FAIL stall_order[%0d] got=%0h exp=%0h", i, got_pc_q[i], exp_q[i]); end
    end
    total++; if (req_q.size() == 0 || req_q[0] !== 32'h8) begin bad++; $display("FAIL stall_resume got=%0h exp=8", req_q[0]); end
  endtask

  task automatic test_branch_run();
    do_reset(1, 1'b0);
    repeat (10) tick();
    clear_q();
    bus.br_taken = 1'b1;
    bus.br_target = 32'h103;
    #1;
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL brrun_req got=%0h exp=0", bus.imem_req); end
    tick();
    bus.br_taken = 1'b0;
    #1;
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL brrun_valid got=%0h exp=0", bus.if_valid); end
    total++; if (bus.fifo_count !== 2'd0) begin bad++; $display("FAIL brrun_count got=%0d exp=0", bus.fifo_count); end
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100)
      begin bad++; $display("FAIL brrun_target got=%0h/%0h exp=1/100", bus.imem_req, bus.imem_addr); end
    bus.if_ready = 1'b1;
    for (int i = 0; i < 20 && got_pc_q.size() < 2; i++) tick();
    total++; if (got_pc_q.size() < 2) begin bad++; $display("FAIL brrun_timeout got=%0d exp=2", got_pc_q.size()); end
    exp_q = '{32'h100, 32'h104};
    for (int i = 0; i < 2; i++) begin
      total++; if (i >= got_pc_q.size() || got_pc_q[i] !== exp_q[i] || got_in_q[i] !== mem_word(exp_q[i]))
        begin bad++; $display("FAIL brrun_stream[%0d] got=%0h exp=%0h", i, got_pc_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_branch_wait();
    do_reset(3, 1'b1);
    tick();
    total++; if (bus.fsm_state !== WAIT) begin bad++; $display("FAIL brwait_pre got=%0d exp=%0d", bus.fsm_state, WAIT); end
    bus.br_taken = 1'b1;
    bus.br_target = 32'h200;
    tick();
    bus.br_taken = 1'b0;
    total++; if (bus.fsm_state !== DROP) begin bad++; $display("FAIL brwait_drop got=%0d exp=%0d", bus.fsm_state, DROP); end
    tick();
    total++; if (bus.fsm_state !== DROP) begin bad++; $display("FAIL brwait_hold got=%0d exp=%0d", bus.fsm_state, DROP); end
    tick();
    total++; if (bus.fsm_state !== RUN || bus.fifo_count !== 2'd0)
      begin bad++; $display("FAIL brwait_discard got=%0d/%0d exp=%0d/0", bus.fsm_state, bus.fifo_count, RUN); end
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200)
      begin bad++; $display("FAIL brwait_target got=%0h/%0h exp=1/200", bus.imem_req, bus.imem_addr); end
    for (int i = 0; i < 20 && got_pc_q.size() < 1; i++) tick();
    total++; if (got_pc_q.size() == 0 || got_pc_q[0] !== 32'h200 || got_in_q[0] !== mem_word(32'h200))
      begin bad++; $display("FAIL brwait_first got=%0h exp=200", got_pc_q[0]); end
  endtask

  task automatic test_branch_rvalid();
    do_reset(1, 1'b0);
    tick();
    total++; if (bus.fsm_state !== WAIT) begin bad++; $display("FAIL brrv_pre got=%0d exp=%0d", bus.fsm_state, WAIT); end
    bus.br_taken = 1'b1;
    bus.br_target = 32'h300;
    tick();
    bus.br_taken = 1'b0;
    #1;
    total++; if (bus.fifo_count !== 2'd0 || bus.if_valid !== 1'b0)
      begin bad++; $display("FAIL brrv_nopush got=%0d/%0h exp=0/0", bus.fifo_count, bus.if_valid); end
    total++; if (bus.fsm_state !== RUN) begin bad++; $display("FAIL brrv_state got=%0d exp=%0d", bus.fsm_state, RUN); end
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300)
      begin bad++; $display("FAIL brrv_target got=%0h/%0h exp=1/300", bus.imem_req, bus.imem_addr); end
    bus.if_ready = 1'b1;
    for (int i = 0; i < 20 && got_pc_q.size() < 1; i++) tick();
    total++; if (got_pc_q.size() == 0 || got_pc_q[0] !== 32'h300 || got_in_q[0] !== mem_word(32'h300))
      begin bad++; $display("FAIL brrv_first got=%0h exp=300", got_pc_q[0]); end
  endtask

  task automatic test_rst_mid_wait();
    do_reset(2, 1'b0);
    for (int i = 0; i < 20 && !(bus.fifo_count == 2'd1 && bus.fsm_state == WAIT); i++) tick();
    total++; if (bus.fifo_count !== 2'd1 || bus.fsm_state !== WAIT || bus.if_valid !== 1'b1)
      begin bad++; $display("FAIL rstmid_setup got=%0d/%0d exp=1/%0d", bus.fifo_count, bus.fsm_state, WAIT); end
    rst = 1'b1;
    #1;
    total++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0)
      begin bad++; $display("FAIL rstmid_imem got=%0h/%0h exp=0/0", bus.imem_req, bus.imem_addr); end
    total++; if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0)
      begin bad++; $display("FAIL rstmid_if got=%0h/%0h/%0h exp=0/0/0", bus.if_valid, bus.if_instr, bus.if_pc); end
    total++; if (bus.fsm_state !== RUN || bus.fifo_count !== 2'd0)
      begin bad++; $display("FAIL rstmid_state got=%0d/%0d exp=%0d/0", bus.fsm_state, bus.fifo_count, RUN); end
    tick();
    rst = 1'b0;
    tick();
    total++; if (bus.fifo_count !== 2'd0 || bus.fsm_state !== WAIT)
      begin bad++; $display("FAIL rstmid_stray got=%0d/%0d exp=0/%0d", bus.fifo_count, bus.fsm_state, WAIT); end
    for (int i = 0; i < 20 && !bus.if_valid; i++) tick();
    total++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== mem_word(32'h0))
      begin bad++; $display("FAIL rstmid_refetch got=%0h/%0h exp=0/%0h", bus.if_pc, bus.if_instr, mem_word(32'h0)); end
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    do_reset(1, 1'b0);
    total++; if (stat_flush_cnt !== 16'd0) begin bad++; $display("FAIL stats_rst got=%0h exp=0", stat_flush_cnt); end
    for (int i = 0; i < 3; i++) begin
      bus.br_taken = 1'b1;
      tick();
      bus.br_taken = 1'b0;
      tick();
    end
    total++; if (stat_flush_cnt !== 16'd3) begin bad++; $display("FAIL stats_three got=%0h exp=3", stat_flush_cnt); end
    bus.br_taken = 1'b1;
    repeat (65532) tick();
    bus.br_taken = 1'b0;
    tick();
    total++; if (stat_flush_cnt !== 16'hFFFF) begin bad++; $display("FAIL stats_max got=%0h exp=ffff", stat_flush_cnt); end
    bus.br_taken = 1'b1;
    tick();
    bus.br_taken = 1'b0;
    tick();
    total++; if (stat_flush_cnt !== 16'hFFFF) begin bad++; $display("FAIL stats_sat got=%0h exp=ffff", stat_flush_cnt); end
  endtask
`endif

  initial begin
    bus.if_ready = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    test_reset();
    test_stall();
    test_branch_run();
    test_branch_wait();
    test_branch_rvalid();
    test_rst_mid_wait();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
